// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, header layout and parity helper for the router packet builder
package router_pkg;

    // Header byte layout: {2'b00, len[3:0], dest[1:0]}
    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 4;

    localparam int MAX_LEN_DEFAULT    = 15;
    localparam int GAP_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WAIT_RTR,
        ST_HDR,
        ST_DATA,
        ST_PAR,
        ST_GAP
    } state_t;

    // Running parity is a plain byte-wise XOR.
    function automatic logic [7:0] parity_xor(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [7:0] make_header(input logic [1:0] dest, input logic [3:0] len);
        logic [7:0] h;
        h = '0;
        h[DEST_LSB +: DEST_W] = dest;
        h[LEN_LSB +: LEN_W]   = len;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// rtl/router_pkt_buf.sv - payload byte buffer with clear, write port and read port
module router_pkt_buf #(
    parameter int MAX_LEN = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [3:0] wr_ptr,
    output logic [3:0] rd_ptr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [MAX_LEN];

    // Pointers restart at zero for every packet, so they never wrap.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
        end
    end

    // Storage is not reset; every byte is written before it is read back.
    always_ff @(posedge clk) begin
        if (wr_en && !clear && (int'(wr_ptr) < MAX_LEN)) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Asynchronous read so DATA can emit one byte per cycle with no bubble.
    always_comb begin
        rd_data = '0;
        if (int'(rd_ptr) < MAX_LEN) begin
            rd_data = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/router_pkt_builder.sv
// rtl/router_pkt_builder.sv - builds header/data/parity bursts for the 3-channel router
module router_pkt_builder
    import router_pkg::*;
#(
    parameter int MAX_LEN    = MAX_LEN_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_dest,
    input  logic [3:0] cmd_len,
    input  logic       cmd_bad_par,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [7:0] pay_data,
    input  logic       busy_in,
    input  logic       err_in,
    output logic       packet_valid,
    output logic [7:0] datain,
    output logic       status_valid,
    output logic       status_err
);

    state_t     state;
    state_t     state_n;

    logic [1:0] dest_q;
    logic [3:0] len_q;
    logic       bad_q;
    logic [7:0] parity_q;
    logic [7:0] gap_cnt;

    logic       buf_clear;
    logic       buf_wr;
    logic       buf_rd;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [7:0] rd_data;

    logic       cmd_ok;
    logic       last_pay;
    logic       last_data;
    logic       gap_last;
    logic [7:0] header;

    assign cmd_ok    = (cmd_len != 4'd0) && (cmd_dest != 2'd3);
    assign last_pay  = pay_valid && (wr_ptr == (len_q - 4'd1));
    assign last_data = (rd_ptr == (len_q - 4'd1));
    assign gap_last  = (gap_cnt == 8'(GAP_CYCLES - 1));
    assign header    = make_header(dest_q, len_q);

    router_pkt_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_data (pay_data),
        .rd_en   (buf_rd),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and Moore outputs; the burst bytes come straight from state and registers.
    always_comb begin
        state_n      = state;
        cmd_ready    = 1'b0;
        pay_ready    = 1'b0;
        packet_valid = 1'b0;
        datain       = 8'h00;
        buf_clear    = 1'b0;
        buf_wr       = 1'b0;
        buf_rd       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low while reset is applied so every output reads 0 then.
                cmd_ready = resetn;
                if (cmd_valid && cmd_ok) begin
                    buf_clear = 1'b1;
                    state_n   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                pay_ready = 1'b1;
                buf_wr    = pay_valid;
                if (last_pay) begin
                    // Skip the wait state when the router is already free.
                    state_n = busy_in ? ST_WAIT_RTR : ST_HDR;
                end
            end
            ST_WAIT_RTR: begin
                if (!busy_in) begin
                    state_n = ST_HDR;
                end
            end
            ST_HDR: begin
                packet_valid = 1'b1;
                datain       = header;
                state_n      = ST_DATA;
            end
            ST_DATA: begin
                packet_valid = 1'b1;
                datain       = rd_data;
                buf_rd       = 1'b1;
                if (last_data) begin
                    state_n = ST_PAR;
                end
            end
            ST_PAR: begin
                packet_valid = 1'b1;
                datain       = bad_q ? ~parity_q : parity_q;
                state_n      = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Command latch, running parity, gap timer and the per-packet status pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dest_q       <= '0;
            len_q        <= '0;
            bad_q        <= 1'b0;
            parity_q     <= '0;
            gap_cnt      <= '0;
            status_valid <= 1'b0;
            status_err   <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            status_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_ok) begin
                            dest_q   <= cmd_dest;
                            len_q    <= cmd_len;
                            bad_q    <= cmd_bad_par;
                            parity_q <= make_header(cmd_dest, cmd_len);
                        end else begin
                            // Unroutable command: report an error without sending anything.
                            status_valid <= 1'b1;
                            status_err   <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (pay_valid) begin
                        parity_q <= parity_xor(parity_q, pay_data);
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        // Router raises err two cycles after the parity byte.
                        gap_cnt      <= '0;
                        status_valid <= 1'b1;
                        status_err   <= err_in;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_builder.sv
// tb/tb_router_pkt_builder.sv - self-checking bench for router_pkt_builder
module tb_router_pkt_builder;

    localparam int GAP = 2;

    typedef logic [7:0] pl_t [16];

    typedef struct {
        logic [1:0] dest;
        logic [3:0] len;
        logic       bad;
        logic       err;
        logic [7:0] b0;
        logic [7:0] step;
        logic       toggle;
        int         busy;
        logic [7:0] exp_hdr;
        logic [7:0] exp_par;
        logic       exp_err;
    } vec_t;

    logic       clk;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [3:0] cmd_len;
    logic       cmd_bad_par;
    logic       pay_valid;
    logic       pay_ready;
    logic [7:0] pay_data;
    logic       busy_in;
    logic       err_in;
    logic       packet_valid;
    logic [7:0] datain;
    logic       status_valid;
    logic       status_err;

    int         n_pass;
    int         n_total;
    int         cyc;
    int         runs;
    int         first_pv;
    int         zero_viol;
    logic       prev_pv;
    logic [7:0] obs [$];
    logic [7:0] exp_q [$];
    logic       st_q [$];
    int         st_cyc_q [$];

    router_pkt_builder dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dest     (cmd_dest),
        .cmd_len      (cmd_len),
        .cmd_bad_par  (cmd_bad_par),
        .pay_valid    (pay_valid),
        .pay_ready    (pay_ready),
        .pay_data     (pay_data),
        .busy_in      (busy_in),
        .err_in       (err_in),
        .packet_valid (packet_valid),
        .datain       (datain),
        .status_valid (status_valid),
        .status_err   (status_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        runs      = 0;
        first_pv  = -1;
        zero_viol = 0;
        prev_pv   = 1'b0;
        forever begin
            @(negedge clk);
            if (packet_valid) begin
                obs.push_back(datain);
                if (!prev_pv) begin
                    runs++;
                    if (first_pv < 0) first_pv = cyc;
                end
            end else if (datain != 8'h00) begin
                zero_viol++;
            end
            prev_pv = packet_valid;
            if (status_valid) begin
                st_q.push_back(status_err);
                st_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: header, payload, then XOR of everything before it (inverted on request).
    function automatic void build_exp(input logic [1:0] d, input logic [3:0] l, input logic b, input pl_t pl);
        logic [7:0] p;
        exp_q.delete();
        if (l == 0 || d == 3) return;
        p = {2'b00, l, d};
        exp_q.push_back(p);
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(pl[i]);
            p = p ^ pl[i];
        end
        exp_q.push_back(b ? ~p : p);
    endfunction

    task automatic send_cmd(input logic [1:0] d, input logic [3:0] l, input logic b, output int hs);
        int n;
        bit got;
        n = 0;
        got = 0;
        hs = -1;
        cmd_dest = d;
        cmd_len = l;
        cmd_bad_par = b;
        cmd_valid = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                hs = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!got) chk("cmd_handshake_timeout", 0, 1);
    endtask

    task automatic send_payload(input logic [3:0] l, input logic toggle, input pl_t pl, output int hs);
        int n;
        bit got;
        hs = -1;
        for (int i = 0; i < int'(l); i++) begin
            if (toggle) begin
                pay_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            pay_data = pl[i];
            pay_valid = 1'b1;
            n = 0;
            got = 0;
            while (!got && n < 100) begin
                @(negedge clk);
                if (pay_ready) begin
                    got = 1;
                    hs = cyc;
                end
                @(posedge clk);
                #1;
                n++;
            end
            if (!got) chk("pay_handshake_timeout", 0, 1);
        end
        pay_valid = 1'b0;
    endtask

    task automatic run_packet(input logic [1:0] d, input logic [3:0] l, input logic b, input logic e,
                              input int err_gap, input logic toggle, input int busy_cyc, input pl_t pl);
        bit valid;
        int hs_cmd, hs_pay, n, nbad, exp_first, exp_st;
        logic exp_err;
        valid = (l != 0) && (d != 3);
        obs.delete();
        st_q.delete();
        st_cyc_q.delete();
        runs = 0;
        first_pv = -1;
        hs_pay = -1;
        err_in = e;
        send_cmd(d, l, b, hs_cmd);
        if (valid) begin
            if (busy_cyc > 0) busy_in = 1'b1;
            send_payload(l, toggle, pl, hs_pay);
            for (int i = 0; i < busy_cyc; i++) begin
                @(posedge clk);
                #1;
            end
            busy_in = 1'b0;
            if (err_gap > 0) begin
                for (int i = 0; i < int'(l) + 1 + err_gap; i++) begin
                    @(posedge clk);
                    #1;
                end
                err_in = 1'b1;
                @(posedge clk);
                #1;
                err_in = 1'b0;
            end
        end
        n = 0;
        while (st_q.size() == 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        err_in = 1'b0;

        build_exp(d, l, b, pl);
        exp_err   = valid ? (e | (err_gap == 2)) : 1'b1;
        exp_first = valid ? ((busy_cyc > 0) ? hs_pay + 2 + busy_cyc : hs_pay + 1) : -1;
        exp_st    = valid ? exp_first + int'(l) + 2 + GAP : hs_cmd + 1;

        chk("burst_len", obs.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            if (obs[i] != exp_q[i]) nbad++;
        end
        chk("burst_byte_errors", nbad, 0);
        chk("burst_runs", runs, valid ? 1 : 0);
        if (valid) chk("header_cycle", first_pv, exp_first);
        chk("status_pulses", st_q.size(), 1);
        if (st_q.size() > 0) begin
            chk("status_err", int'(st_q[0]), int'(exp_err));
            chk("status_cycle", st_cyc_q[0], exp_st);
        end
    endtask

    vec_t vt [8];
    pl_t  pl;
    int   hs;

    initial begin
        n_pass = 0;
        n_total = 0;
        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_dest = '0;
        cmd_len = '0;
        cmd_bad_par = 1'b0;
        pay_valid = 1'b0;
        pay_data = '0;
        busy_in = 1'b0;
        err_in = 1'b0;
        for (int i = 0; i < 16; i++) pl[i] = '0;

        vt[0] = '{2'd1, 4'd3,  1'b0, 1'b0, 8'h11, 8'h11, 1'b0, 0, 8'h0D, 8'h0D, 1'b0};
        vt[1] = '{2'd1, 4'd3,  1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 0, 8'h0D, 8'hF2, 1'b0};
        vt[2] = '{2'd0, 4'd1,  1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 8'h04, 8'hA1, 1'b0};
        vt[3] = '{2'd2, 4'd2,  1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 0, 8'h0A, 8'h09, 1'b1};
        vt[4] = '{2'd1, 4'd3,  1'b0, 1'b0, 8'h11, 8'h11, 1'b0, 4, 8'h0D, 8'h0D, 1'b0};
        vt[5] = '{2'd0, 4'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, 1'b1};
        vt[6] = '{2'd3, 4'd2,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, 1'b1};
        vt[7] = '{2'd2, 4'd15, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 0, 8'h3E, 8'h31, 1'b0};

        // Outputs while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_packet_valid", int'(packet_valid), 0);
        chk("rst_datain", int'(datain), 0);
        chk("rst_status_valid", int'(status_valid), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_pay_ready", int'(pay_ready), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) pl[i] = vt[v].b0 + 8'(i) * vt[v].step;
            run_packet(vt[v].dest, vt[v].len, vt[v].bad, vt[v].err, 0, vt[v].toggle, vt[v].busy, pl);
            if (vt[v].exp_err && vt[v].len != 0 && vt[v].dest != 3) begin
                chk("tbl_err_flag", int'(st_q.size() > 0 ? st_q[0] : 1'b0), 1);
            end
            if (vt[v].len != 0 && vt[v].dest != 3) begin
                chk("tbl_len", obs.size(), int'(vt[v].len) + 2);
                if (obs.size() > 1) begin
                    chk("tbl_hdr", int'(obs[0]), int'(vt[v].exp_hdr));
                    chk("tbl_par", int'(obs[obs.size() - 1]), int'(vt[v].exp_par));
                end
            end else begin
                chk("tbl_no_burst", obs.size(), 0);
                chk("tbl_bad_status", int'(st_q.size() > 0 ? st_q[0] : 1'b0), int'(vt[v].exp_err));
            end
        end

        // err_in pulsed only in the final gap cycle is reported; in the first gap cycle it is not.
        for (int i = 0; i < 16; i++) pl[i] = 8'h11 + 8'(i) * 8'h11;
        run_packet(2'd1, 4'd3, 1'b1, 1'b0, 2, 1'b0, 0, pl);
        if (obs.size() == 5) chk("gap2_par_byte", int'(obs[4]), 8'hF2);
        run_packet(2'd1, 4'd3, 1'b0, 1'b0, 1, 1'b0, 0, pl);

        // Reset in the middle of DATA abandons the packet silently.
        obs.delete();
        st_q.delete();
        st_cyc_q.delete();
        for (int i = 0; i < 16; i++) pl[i] = 8'h80 + 8'(i);
        send_cmd(2'd1, 4'd8, 1'b0, hs);
        send_payload(4'd8, 1'b0, pl, hs);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_pv_before", int'(packet_valid), 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_pv_after", int'(packet_valid), 0);
        chk("midrst_datain_after", int'(datain), 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_no_status", st_q.size(), 0);
        for (int i = 0; i < 16; i++) pl[i] = '0;
        pl[0] = 8'h5A;
        run_packet(2'd0, 4'd1, 1'b0, 1'b0, 0, 1'b0, 0, pl);
        if (obs.size() == 3) chk("midrst_next_par", int'(obs[2]), 8'h5E);

        // Randomized packets against the reference model.
        for (int r = 0; r < 25; r++) begin
            logic [1:0] d;
            logic [3:0] l;
            d = 2'($urandom_range(0, 3));
            if (d == 2'd3 && $urandom_range(0, 2) != 0) d = 2'($urandom_range(0, 2));
            l = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
            run_packet(d, l, 1'($urandom), 1'($urandom), 0, 1'($urandom),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0, pl);
        end

        chk("datain_zero_when_idle", zero_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
